iic_reg_seq: RTL
================

Name: iic_reg_seq

Overview:
Transaction sequencer sitting between a register-access client (config FSM or CPU bridge) and the iic_mst byte-level command engine. Accepts one single-byte register write or read request, expands it into the iic_mst command stream (START / WRDATA / RDDATA / PRE_START / STOP), checks slave ACKs, and returns read data plus status. Owns the iic_mst command port exclusively.

Parameters:
SYS_CLOCK, 50000000, system clock frequency in Hz.
IIC_CLOCK, 100000, SCL frequency in Hz; used only to size the watchdog.
CMD_TIMEOUT, 16*SYS_CLOCK/IIC_CLOCK, max cycles to wait for i_Done per command before abort.

Ports:
i_SysClock  in  1  system clock.
i_ResetN  in  1  async active-low reset.
i_ReqValid  in  1  request strobe from client.
o_ReqReady  out  1  high in IDLE only; request accepted when i_ReqValid && o_ReqReady.
i_ReqRead  in  1  1 = register read, 0 = register write.
i_DevAddr  in  7  7-bit slave address.
i_RegAddr  in  8  register address byte.
i_WrData  in  8  write data byte.
o_RspValid  out  1  one-cycle pulse at end of transaction.
o_RspData  out  8  read byte; valid with o_RspValid on successful read, else 0x00.
o_RspNack  out  1  slave NACKed an address/register/data byte; qualified by o_RspValid.
o_RspTimeout  out  1  watchdog expired; qualified by o_RspValid.
o_CmdValid  out  1  to iic_mst i_CmdValid.
o_Cmd  out  4  to iic_mst i_Cmd (1 START, 2 WRDATA, 3 RDDATA, 4 STOP, 5 PRE_START).
o_TxByte  out  8  to iic_mst i_TxByte.
o_SetAck  out  1  to iic_mst i_SetAck; 1 = master NACKs the read byte.
i_Done  in  1  from iic_mst o_Done (high = engine idle).
i_RxByte  in  8  from iic_mst o_RxByte.
i_GetAck  in  1  from iic_mst o_GetAck (0 = ACK, 1 = NACK).

Behaviour:
- Reset: all outputs 0 except o_ReqReady=1; FSM IDLE; step index 0; latched request cleared. Reset mid-transaction abandons it immediately, no STOP issued, no response.
- Request latched on accept (dev, reg, data, read flag); inputs ignored afterwards.
- Step lists. Write: START, WR {Dev,0}, WR Reg, WR Data, STOP. Read: START, WR {Dev,0}, WR Reg, PRE_START, START, WR {Dev,1}, RD (o_SetAck=1), STOP.
- Per-step FSM: IDLE -> ISSUE -> ACCEPT -> WAIT -> CHECK -> ISSUE (next step) ... -> RESP -> IDLE.
- ISSUE: entered only when i_Done=1; drive o_CmdValid=1 with o_Cmd/o_TxByte/o_SetAck for exactly one cycle. o_TxByte=0x00 for non-data commands; o_SetAck=0 except RD step.
- ACCEPT: one dead cycle, o_CmdValid=0 (engine lowers i_Done the cycle after acceptance).
- WAIT: hold until i_Done=1; then CHECK. Watchdog counter cleared on ISSUE, increments in ACCEPT/WAIT; reaching CMD_TIMEOUT -> RESP with o_RspTimeout=1, no STOP (engine is assumed hung).
- CHECK after any WR step: i_GetAck=1 -> set nack flag, jump directly to STOP step (remaining bytes skipped). After RD step: capture i_RxByte into data register. After STOP: go to RESP.
- RESP: o_RspValid=1 one cycle with o_RspNack/o_RspTimeout/o_RspData; o_RspData=0x00 unless read completed with no nack. Next cycle IDLE, o_ReqReady=1.
- o_RspNack and o_RspTimeout never both 1. o_RspValid and o_ReqReady never high together.
- Request held during busy time is not accepted until IDLE; back-to-back: accepting a new request in the cycle after RESP is legal.
- If i_Done=0 on entry to ISSUE (engine busy from outside), stay in ISSUE with o_CmdValid=0; watchdog runs.

Test Plan:
- Write dev 0x50 reg 0x10 data 0xA5, mock acks all -> commands START, WR 0xA0, WR 0x10, WR 0xA5, STOP; each CmdValid single-cycle; RspValid with Nack=0, Timeout=0, Data=0x00.
- Read dev 0x50 reg 0x10, mock returns RxByte 0x3C -> START, WR 0xA0, WR 0x10, PRE_START, START, WR 0xA1, RD with SetAck=1, STOP; RspData=0x3C, Nack=0.
- Read with GetAck=1 after WR 0xA0 -> next command STOP, no WR 0x10; RspNack=1, RspData=0x00.
- Mock holds i_Done low after WR 0x10 -> RspValid with Timeout=1 exactly CMD_TIMEOUT cycles after that ISSUE; no STOP issued; ReqReady returns next cycle.
- Assert i_ReqValid continuously with changing data during a write -> only first request executed; second accepted the cycle after RspValid, commands match its latched values.
- Assert i_ResetN low during WAIT of WR data step -> all outputs to reset values asynchronously, ReqReady=1 after release, no RspValid.

Source files
------------

// File: rtl/iic_reg_seq.sv
// Register-access sequencer for the iic_mst byte engine: expands one single-byte
// register write/read into START/WRDATA/RDDATA/PRE_START/STOP commands and reports status.
module iic_reg_seq #(
  parameter int SYS_CLOCK   = 50000000,
  parameter int IIC_CLOCK   = 100000,
  parameter int CMD_TIMEOUT = 16*SYS_CLOCK/IIC_CLOCK
) (
  input  logic       i_SysClock,
  input  logic       i_ResetN,
  input  logic       i_ReqValid,
  output logic       o_ReqReady,
  input  logic       i_ReqRead,
  input  logic [6:0] i_DevAddr,
  input  logic [7:0] i_RegAddr,
  input  logic [7:0] i_WrData,
  output logic       o_RspValid,
  output logic [7:0] o_RspData,
  output logic       o_RspNack,
  output logic       o_RspTimeout,
  output logic       o_CmdValid,
  output logic [3:0] o_Cmd,
  output logic [7:0] o_TxByte,
  output logic       o_SetAck,
  input  logic       i_Done,
  input  logic [7:0] i_RxByte,
  input  logic       i_GetAck
);

  localparam int WDW = $clog2(CMD_TIMEOUT + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_ACCEPT = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_CHECK  = 3'd4;
  localparam logic [2:0] S_RESP   = 3'd5;

  localparam logic [3:0] C_START = 4'd1;
  localparam logic [3:0] C_WR    = 4'd2;
  localparam logic [3:0] C_RD    = 4'd3;
  localparam logic [3:0] C_STOP  = 4'd4;
  localparam logic [3:0] C_PRE   = 4'd5;

  logic [2:0]     state_q, state_d;
  logic [2:0]     step_q, step_d;
  logic           rd_q, rd_d;
  logic [6:0]     dev_q, dev_d;
  logic [7:0]     reg_q, reg_d;
  logic [7:0]     wd_q, wd_d;
  logic [7:0]     data_q, data_d;
  logic           nack_q, nack_d;
  logic           to_q, to_d;
  logic [WDW-1:0] wdog_q, wdog_d;

  logic [3:0] cmd_s;
  logic [7:0] byte_s;
  logic       setack_s;
  logic [2:0] stop_step;
  logic       wd_hit;

  // Step list: the current step index decodes to the command for this request type.
  always_comb begin
    cmd_s    = C_STOP;
    byte_s   = 8'h00;
    setack_s = 1'b0;
    if (rd_q) begin
      case (step_q)
        3'd0: cmd_s = C_START;
        3'd1: begin cmd_s = C_WR; byte_s = {dev_q, 1'b0}; end
        3'd2: begin cmd_s = C_WR; byte_s = reg_q; end
        3'd3: cmd_s = C_PRE;
        3'd4: cmd_s = C_START;
        3'd5: begin cmd_s = C_WR; byte_s = {dev_q, 1'b1}; end
        3'd6: begin cmd_s = C_RD; setack_s = 1'b1; end
        default: cmd_s = C_STOP;
      endcase
    end else begin
      case (step_q)
        3'd0: cmd_s = C_START;
        3'd1: begin cmd_s = C_WR; byte_s = {dev_q, 1'b0}; end
        3'd2: begin cmd_s = C_WR; byte_s = reg_q; end
        3'd3: begin cmd_s = C_WR; byte_s = wd_q; end
        default: cmd_s = C_STOP;
      endcase
    end
  end

  assign stop_step = rd_q ? 3'd7 : 3'd4;
  // Counter holds cycles elapsed since the issue cycle; the response lands exactly CMD_TIMEOUT later.
  assign wd_hit    = (wdog_q == WDW'(CMD_TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    rd_d    = rd_q;
    dev_d   = dev_q;
    reg_d   = reg_q;
    wd_d    = wd_q;
    data_d  = data_q;
    nack_d  = nack_q;
    to_d    = to_q;
    wdog_d  = wdog_q;
    case (state_q)
      S_IDLE: if (i_ReqValid) begin
        rd_d    = i_ReqRead;
        dev_d   = i_DevAddr;
        reg_d   = i_RegAddr;
        wd_d    = i_WrData;
        step_d  = 3'd0;
        data_d  = 8'h00;
        nack_d  = 1'b0;
        to_d    = 1'b0;
        wdog_d  = '0;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (i_Done) begin
          wdog_d  = WDW'(1);
          state_d = S_ACCEPT;
        end else if (wd_hit) begin
          to_d    = 1'b1;
          state_d = S_RESP;
        end else begin
          wdog_d  = wdog_q + WDW'(1);
        end
      end
      S_ACCEPT: begin
        if (wd_hit) begin
          to_d    = 1'b1;
          state_d = S_RESP;
        end else begin
          wdog_d  = wdog_q + WDW'(1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_Done) begin
          state_d = S_CHECK;
        end else if (wd_hit) begin
          to_d    = 1'b1;
          state_d = S_RESP;
        end else begin
          wdog_d  = wdog_q + WDW'(1);
        end
      end
      S_CHECK: begin
        wdog_d  = '0;
        state_d = S_ISSUE;
        if (cmd_s == C_STOP) begin
          state_d = S_RESP;
        end else if (cmd_s == C_WR && i_GetAck) begin
          nack_d = 1'b1;
          step_d = stop_step;
        end else begin
          if (cmd_s == C_RD) data_d = i_RxByte;
          step_d = step_q + 3'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_SysClock or negedge i_ResetN) begin
    if (!i_ResetN) begin
      state_q <= S_IDLE;
      step_q  <= 3'd0;
      rd_q    <= 1'b0;
      dev_q   <= 7'h00;
      reg_q   <= 8'h00;
      wd_q    <= 8'h00;
      data_q  <= 8'h00;
      nack_q  <= 1'b0;
      to_q    <= 1'b0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      rd_q    <= rd_d;
      dev_q   <= dev_d;
      reg_q   <= reg_d;
      wd_q    <= wd_d;
      data_q  <= data_d;
      nack_q  <= nack_d;
      to_q    <= to_d;
      wdog_q  <= wdog_d;
    end
  end

  assign o_ReqReady   = (state_q == S_IDLE);
  assign o_CmdValid   = (state_q == S_ISSUE) && i_Done;
  assign o_Cmd        = o_CmdValid ? cmd_s : 4'd0;
  assign o_TxByte     = o_CmdValid ? byte_s : 8'h00;
  assign o_SetAck     = o_CmdValid & setack_s;
  assign o_RspValid   = (state_q == S_RESP);
  assign o_RspTimeout = o_RspValid & to_q;
  assign o_RspNack    = o_RspValid & nack_q & ~to_q;
  assign o_RspData    = (o_RspValid && rd_q && !nack_q && !to_q) ? data_q : 8'h00;

endmodule
